jk_bank_sequencer: RTL and testbench

//  Command-driven controller for a bank of WIDTH external JK flip-flops (JK cells on the same clk).

---
 rtl/jk_bank_sequencer.sv | 178 +++++++++++++++++
 tb/tb_jk_bank_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_sequencer.sv
// Command-driven controller for an external bank of JK flip-flops.
// Decodes one command per handshake into per-bit J/K drive, then reads Q back and checks it
// against the value the command should have produced. COUNT ops repeat the apply/check step.
module jk_bank_sequencer #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] steps_done
);

   typedef enum logic [1:0] {StIdle, StApply, StCheck} state_e;

   localparam logic [2:0] OpHold  = 3'd0;
   localparam logic [2:0] OpClear = 3'd1;
   localparam logic [2:0] OpSet   = 3'd2;
   localparam logic [2:0] OpLoad  = 3'd3;
   localparam logic [2:0] OpInv   = 3'd4;
   localparam logic [2:0] OpUp    = 3'd5;
   localparam logic [2:0] OpDown  = 3'd6;
   localparam logic [2:0] OpRsvd  = 3'd7;

   localparam logic [WIDTH-1:0] QOne    = WIDTH'(1);
   localparam logic [CNT_W:0]   StepOne = (CNT_W + 1)'(1);

   state_e           state_q;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] data_q;
   logic [CNT_W-1:0] count_q;
   logic [WIDTH-1:0] expected_q;
   logic             done_q;
   logic             err_q;
   logic [CNT_W-1:0] steps_q;

   logic [WIDTH-1:0] up_t;
   logic [WIDTH-1:0] dn_t;
   logic [WIDTH-1:0] next_val;
   logic [CNT_W:0]   steps_inc;
   logic             op_is_count;

   // Toggle enables for binary count: bit i flips when all lower bits are 1 (up) or 0 (down)
   always_comb begin
      logic all_ones;
      logic all_zero;
      up_t     = '0;
      dn_t     = '0;
      all_ones = 1'b1;
      all_zero = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         up_t[i]  = all_ones;
         dn_t[i]  = all_zero;
         all_ones = all_ones & q[i];
         all_zero = all_zero & ~q[i];
      end
   end

   // J/K drive is only non-zero during APPLY; value the bank should hold after the APPLY edge
   always_comb begin
      j        = '0;
      k        = '0;
      next_val = q;
      case (op_q)
         OpClear: begin
            k        = '1;
            next_val = '0;
         end
         OpSet: begin
            j        = '1;
            next_val = '1;
         end
         OpLoad: begin
            j        = data_q;
            k        = ~data_q;
            next_val = data_q;
         end
         OpInv: begin
            j        = '1;
            k        = '1;
            next_val = ~q;
         end
         OpUp: begin
            j        = up_t;
            k        = up_t;
            next_val = q + QOne;
         end
         OpDown: begin
            j        = dn_t;
            k        = dn_t;
            next_val = q - QOne;
         end
         default: begin
            j        = '0;
            k        = '0;
            next_val = q;
         end
      endcase
      if (state_q != StApply) begin
         j = '0;
         k = '0;
      end
   end

   assign op_is_count = (op_q == OpUp) || (op_q == OpDown);
   assign steps_inc   = {1'b0, steps_q} + StepOne;
   assign cmd_ready   = (state_q == StIdle) && !rst;
   assign busy        = (state_q != StIdle);
   assign done        = done_q;
   assign err         = err_q;
   assign steps_done  = steps_q;

   // Sequencer FSM with registered completion flags and step counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         op_q       <= OpHold;
         data_q     <= '0;
         count_q    <= '0;
         expected_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         steps_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (cmd_valid && cmd_ready) begin
                  op_q    <= cmd_op;
                  data_q  <= cmd_data;
                  count_q <= cmd_count;
                  steps_q <= '0;
                  err_q   <= 1'b0;
                  if (cmd_op == OpRsvd) begin
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                  end else if (((cmd_op == OpUp) || (cmd_op == OpDown)) && (cmd_count == '0)) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= StApply;
                  end
               end
            end
            StApply: begin
               expected_q <= next_val;
               state_q    <= StCheck;
            end
            StCheck: begin
               steps_q <= steps_inc[CNT_W-1:0];
               if (q != expected_q) begin
                  // Mismatch abandons any remaining count steps
                  state_q <= StIdle;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
               end else if (op_is_count && (steps_inc < {1'b0, count_q})) begin
                  state_q <= StApply;
               end else begin
                  state_q <= StIdle;
                  done_q  <= 1'b1;
                  err_q   <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench: jk_bank_sequencer driving a behavioural 4-bit JK bank.
module tb_jk_bank_sequencer;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned CNT_W = 8;

   logic             clk;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [CNT_W-1:0] cmd_count;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] steps_done;

   logic             bank_init;
   logic             stuck;
   logic [WIDTH-1:0] stuck_val;
   logic [WIDTH-1:0] bank_q;

   int n_checks;
   int n_errors;

   jk_bank_sequencer #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_data   (cmd_data),
      .cmd_count  (cmd_count),
      .q          (q),
      .j          (j),
      .k          (k),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .steps_done (steps_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural JK bank; can be forced to a stuck value to create a readback fault
   always_ff @(posedge clk) begin
      if (bank_init) bank_q <= '0;
      else if (stuck) bank_q <= stuck_val;
      else bank_q <= (j & ~bank_q) | (~k & bank_q);
   end
   assign q = bank_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a command on a negedge; returns at the negedge after the accept edge
   task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] data,
                       input logic [CNT_W-1:0] count);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_count = count;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      bank_init = 1'b1;
      stuck     = 1'b0;
      stuck_val = '0;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_data  = '0;
      cmd_count = '0;

      // Reset
      repeat (2) @(negedge clk);
      chk("rst_j", j, 0);
      chk("rst_k", k, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", cmd_ready, 0);
      rst       = 1'b0;
      bank_init = 1'b0;
      #1;
      chk("ready_after_rst", cmd_ready, 1);
      chk("busy_after_rst", busy, 0);

      // LOAD 1010
      send(3'd3, 4'b1010, 8'd0);
      chk("load_apply_j", j, 4'b1010);
      chk("load_apply_k", k, 4'b0101);
      chk("load_apply_busy", busy, 1);
      chk("load_apply_ready", cmd_ready, 0);
      @(negedge clk);
      chk("load_q", q, 4'b1010);
      chk("load_check_j", j, 0);
      @(negedge clk);
      chk("load_done", done, 1);
      chk("load_err", err, 0);
      chk("load_steps", steps_done, 1);
      chk("load_ready_done", cmd_ready, 1);
      @(negedge clk);
      chk("load_done_pulse", done, 0);

      // LOAD 1110 then COUNT_UP 3 with wrap
      send(3'd3, 4'b1110, 8'd0);
      @(negedge clk);
      @(negedge clk);
      chk("load2_q", q, 4'b1110);
      @(negedge clk);
      send(3'd5, 4'b0000, 8'd3);
      chk("up_s1_j", j, 4'b0001);
      chk("up_s1_k", k, 4'b0001);
      @(negedge clk);
      chk("up_s1_q", q, 4'b1111);
      @(negedge clk);
      chk("up_s2_j", j, 4'b1111);
      @(negedge clk);
      chk("up_s2_q", q, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      chk("up_s3_q", q, 4'b0001);
      chk("up_s3_nodone", done, 0);
      @(negedge clk);
      chk("up_done", done, 1);
      chk("up_err", err, 0);
      chk("up_steps", steps_done, 3);

      // CLEAR then COUNT_DOWN 2 with wrap
      @(negedge clk);
      send(3'd1, 4'b0000, 8'd0);
      chk("clear_k", k, 4'b1111);
      @(negedge clk);
      @(negedge clk);
      chk("clear_q", q, 4'b0000);
      @(negedge clk);
      send(3'd6, 4'b0000, 8'd2);
      chk("dn_s1_j", j, 4'b1111);
      @(negedge clk);
      chk("dn_s1_q", q, 4'b1111);
      @(negedge clk);
      chk("dn_s2_j", j, 4'b0001);
      @(negedge clk);
      chk("dn_s2_q", q, 4'b1110);
      @(negedge clk);
      chk("dn_done", done, 1);
      chk("dn_err", err, 0);
      chk("dn_steps", steps_done, 2);

      // COUNT_UP 5 with the bank stuck at 0011 from the first APPLY edge
      @(negedge clk);
      send(3'd5, 4'b0000, 8'd5);
      stuck     = 1'b1;
      stuck_val = 4'b0011;
      chk("stuck_apply_j", j, 4'b0001);
      @(negedge clk);
      chk("stuck_q", q, 4'b0011);
      chk("stuck_busy", busy, 1);
      @(negedge clk);
      chk("stuck_done", done, 1);
      chk("stuck_err", err, 1);
      chk("stuck_steps", steps_done, 1);
      chk("stuck_idle", busy, 0);
      stuck = 1'b0;

      // COUNT_UP with count 0 finishes immediately
      @(negedge clk);
      send(3'd5, 4'b0000, 8'd0);
      chk("cnt0_done", done, 1);
      chk("cnt0_err", err, 0);
      chk("cnt0_steps", steps_done, 0);
      chk("cnt0_busy", busy, 0);

      // Reserved op
      @(negedge clk);
      send(3'd7, 4'b1111, 8'd4);
      chk("rsvd_done", done, 1);
      chk("rsvd_err", err, 1);
      chk("rsvd_j", j, 0);
      chk("rsvd_k", k, 0);
      chk("rsvd_busy", busy, 0);

      // Reset during CHECK of COUNT_UP 10 from 0011
      @(negedge clk);
      send(3'd5, 4'b0000, 8'd10);
      chk("abort_apply_busy", busy, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_ready_rst", cmd_ready, 0);
      chk("abort_steps", steps_done, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_nodone", done, 0);
      chk("abort_ready", cmd_ready, 1);
      chk("abort_bank_kept", q, 4'b0100);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
